la_trace_expander: RTL and testbench
====================================

// Module: la_trace_expander
// PURPOSE
//  AXIS slave that consumes run-length trace packets from the logic-analyzer FIFO output and re-expands them
//  into a cycle-accurate sample stream (one sample per output handshake).
//  Sits directly downstream of the LA trace FIFO/AXIS master; feeds on-chip replay, compare or loopback checkers.
//  Packet format: tdata[31:24]=rc (run length, cycles), tdata[23:0]=masked sample value; 32'h0 = null (overflow gap) packet.
// PARAMETERS
//  SMP_W    24   sample width (tdata[SMP_W-1:0])
//  RC_W      8   run-count width (tdata[31:32-RC_W]); SMP_W+RC_W must equal 32
//  STAT_W   32   width of statistics counters (only with LA_EXP_STATS_EN)
// PORTS
//  axis_clk      in   1       single clock
//  axis_rst_n    in   1       synchronous active-low reset
//  s_tdata       in   32      trace packet
//  s_tvalid      in   1       packet valid
//  s_tready      out  1       packet accepted when s_tvalid&s_tready
//  s_tlast       in   1       end of AXIS burst (pop_cond boundary)
//  s_tuser       in   2       ignored (always 2'b00 from LA)
//  smp_data      out  SMP_W   expanded sample value
//  smp_gap       out  1       sample is an overflow gap marker (render as 'x')
//  smp_end       out  1       last sample of the current run
//  smp_burst_end out  1       last sample of a packet that arrived with s_tlast
//  smp_valid     out  1       sample valid
//  smp_ready     in   1       sample consumed when smp_valid&smp_ready
//  err_clr       in   1       clears err_rc0
//  err_rc0       out  1       sticky: packet with rc==0 and nonzero sample received
// BEHAVIOUR
//  Reset (axis_rst_n==0 at posedge): state=IDLE; s_tready=0 for that cycle; smp_valid=0, smp_data=0, smp_gap=0,
//   smp_end=0, smp_burst_end=0, err_rc0=0, run counter=0. A packet in flight is discarded; no partial run resumes.
//  States: IDLE (no packet held), RUN (expanding held packet).
//   IDLE: s_tready=1. On accept: rc!=0 -> latch {rc,data,tlast}, cnt<=rc, ->RUN.
//         tdata==0 -> latch gap (smp_gap=1, data=0, single sample, cnt<=1), ->RUN.
//         rc==0 & data!=0 -> drop, err_rc0<=1, stay IDLE.
//   RUN: smp_valid=1; each smp handshake decrements cnt. smp_end=(cnt==1); smp_burst_end=smp_end&latched tlast.
//        s_tready=(cnt==1)&smp_ready: the final-sample handshake and the next packet accept coincide -> zero-bubble
//        back-to-back runs; accepted packet loads next cycle, stays RUN. If no packet then, ->IDLE.
//  Latency: packet accept -> first smp_valid next cycle. Total samples per packet = rc (1..2^RC_W-1); rc=255 max.
//  Outputs registered; smp_data/gap/end stable while smp_valid&!smp_ready (AXIS hold rule).
//  cnt is RC_W bits, never wraps (load>=1, decrements to 0 only on final handshake).
//  err_clr and a new rc0 error in same cycle: set wins. s_tuser ignored.
// CONFIGURATION
//  LA_EXP_STATS_EN defined: adds outputs stat_pkts, stat_gaps, stat_smps (STAT_W each, reset 0), counting accepted
//   packets, null packets, and sample handshakes; saturate at all-ones; cleared by err_clr.
//  Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  1 Reset, send 32'h03_00_00A5, smp_ready=1 -> 3 samples 0x0000A5, smp_end only on 3rd, s_tready low cycles 1-2.
//  2 Back-to-back 32'h01_000001, 32'h02_000002 with s_tvalid held -> samples 1,2,2 in 3 consecutive cycles, no bubble.
//  3 Send 32'h0 between runs -> one sample smp_gap=1, smp_data=0, smp_end=1.
//  4 Send 32'h00_000010 -> no sample, err_rc0=1 until err_clr pulse; next valid packet expands normally.
//  5 32'hFF_123456 with smp_ready toggling randomly -> exactly 255 samples, data held while stalled, burst_end if tlast.
//  6 Assert reset mid-run (cnt=100) -> smp_valid=0 next cycle; after release, new packet expands from its own rc.

Source files
------------

// File: rtl/la_trace_expander.sv
// Re-expands run-length trace packets {rc, sample} into one sample per output handshake.
// Optional statistics counters are built when LA_EXP_STATS_EN is defined.
module la_trace_expander #(
  parameter int SMP_W  = 24,
  parameter int RC_W   = 8,
  parameter int STAT_W = 32
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic [31:0]       s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [1:0]        s_tuser,
  output logic [SMP_W-1:0]  smp_data,
  output logic              smp_gap,
  output logic              smp_end,
  output logic              smp_burst_end,
  output logic              smp_valid,
  input  logic              smp_ready,
  input  logic              err_clr,
  output logic              err_rc0,
`ifdef LA_EXP_STATS_EN
  output logic [STAT_W-1:0] stat_pkts,
  output logic [STAT_W-1:0] stat_gaps,
  output logic [STAT_W-1:0] stat_smps,
`endif
  output logic              dbg_state
);

  // Handshakes: a beat moves on either side only in a cycle where valid and
  // ready are both high at the rising edge; valid never waits on ready, and
  // the sample outputs hold steady while smp_valid is high and smp_ready low.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RC_W-1:0] CNT_ONE = RC_W'(1);

  state_t           state_q, state_d;
  logic [RC_W-1:0]  cnt_q, cnt_d;
  logic [SMP_W-1:0] data_q, data_d;
  logic             gap_q, gap_d;
  logic             tlast_q, tlast_d;
  logic             err_q, err_d;

  logic [RC_W-1:0]  pkt_rc;
  logic [SMP_W-1:0] pkt_smp;
  logic             last_hs;
  logic             accept;
  logic             smp_hs;
  logic             unused_tuser;

  assign pkt_rc       = s_tdata[31 -: RC_W];
  assign pkt_smp      = s_tdata[SMP_W-1:0];
  assign unused_tuser = ^s_tuser;

  // The final sample of a run and the next packet share one cycle, so runs
  // can follow each other without a bubble.
  assign last_hs  = (state_q == RUN) && (cnt_q == CNT_ONE) && smp_ready;
  assign s_tready = axis_rst_n && ((state_q == IDLE) || last_hs);
  assign accept   = s_tvalid && s_tready;
  assign smp_hs   = smp_valid && smp_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    gap_d   = gap_q;
    tlast_d = tlast_q;
    err_d   = err_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    if (state_q == RUN && smp_ready) begin
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    if (accept) begin
      if (pkt_rc != '0) begin
        state_d = RUN;
        cnt_d   = pkt_rc;
        data_d  = pkt_smp;
        gap_d   = 1'b0;
        tlast_d = s_tlast;
      end else if (pkt_smp == '0) begin
        state_d = RUN;
        cnt_d   = CNT_ONE;
        data_d  = '0;
        gap_d   = 1'b1;
        tlast_d = s_tlast;
      end else begin
        // Malformed packet: dropped, and a new error beats a same-cycle clear.
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      gap_q   <= 1'b0;
      tlast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      tlast_q <= tlast_d;
      err_q   <= err_d;
    end
  end

  assign smp_valid     = (state_q == RUN);
  assign smp_data      = data_q;
  assign smp_gap       = gap_q;
  assign smp_end       = (state_q == RUN) && (cnt_q == CNT_ONE);
  assign smp_burst_end = smp_end && tlast_q;
  assign err_rc0       = err_q;
  assign dbg_state     = state_q;

`ifdef LA_EXP_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n || err_clr) begin
      stat_pkts <= '0;
      stat_gaps <= '0;
      stat_smps <= '0;
    end else begin
      if (accept && stat_pkts != STAT_MAX) begin
        stat_pkts <= stat_pkts + STAT_ONE;
      end
      if (accept && s_tdata == 32'h0 && stat_gaps != STAT_MAX) begin
        stat_gaps <= stat_gaps + STAT_ONE;
      end
      if (smp_hs && stat_smps != STAT_MAX) begin
        stat_smps <= stat_smps + STAT_ONE;
      end
    end
  end
`else
  logic unused_smp_hs;
  assign unused_smp_hs = smp_hs;
`endif

endmodule

// File: tb/tb_la_trace_expander.sv
// Directed bench for la_trace_expander: packet-level expansion model plus literal spot checks.
module tb_la_trace_expander;

  localparam int SMP_W = 24;
  localparam int EW    = SMP_W + 3;  // {data, gap, end, burst_end}
  localparam int HW    = SMP_W + 4;  // {valid, data, gap, end, burst_end}

  // ---------------- clock / reset / DUT ----------------
  logic             axis_clk = 1'b0;
  logic             axis_rst_n = 1'b0;
  logic [31:0]      s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic             s_tlast = 1'b0;
  logic [1:0]       s_tuser = 2'b00;
  logic [SMP_W-1:0] smp_data;
  logic             smp_gap, smp_end, smp_burst_end, smp_valid;
  logic             smp_ready = 1'b1;
  logic             err_clr = 1'b0;
  logic             err_rc0;
  logic             dbg_state;

  always #5 axis_clk = ~axis_clk;

  la_trace_expander dut (
    .axis_clk      (axis_clk),
    .axis_rst_n    (axis_rst_n),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tlast       (s_tlast),
    .s_tuser       (s_tuser),
    .smp_data      (smp_data),
    .smp_gap       (smp_gap),
    .smp_end       (smp_end),
    .smp_burst_end (smp_burst_end),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .err_clr       (err_clr),
    .err_rc0       (err_rc0),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic          exp_err = 1'b0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            hs_cnt = 0;
  int            be_cnt = 0;
  logic          hold_v = 1'b0;
  logic [HW-1:0] hold_vec = '0;
  logic          rand_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what a packet must turn into, straight from the packet format.
  task automatic model_pkt(input logic [31:0] pkt, input logic last);
    int unsigned rc;
    logic [SMP_W-1:0] d;
    rc = pkt[31:24];
    d  = pkt[23:0];
    if (rc != 0) begin
      for (int i = 0; i < rc; i++) begin
        exp_q.push_back({d, 1'b0, (i == rc - 1), (i == rc - 1) && last});
      end
    end else if (d == 0) begin
      exp_q.push_back({{SMP_W{1'b0}}, 1'b1, 1'b1, last});
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Compare process: one check per meaningful cycle, away from the rising edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge axis_clk);
      if (!axis_rst_n) begin
        hold_v = 1'b0;
      end else begin
        chk("err_rc0", 64'(err_rc0), 64'(exp_err));
        if (hold_v) begin
          chk("hold", 64'({smp_valid, smp_data, smp_gap, smp_end, smp_burst_end}), 64'(hold_vec));
        end
        if (smp_valid && smp_ready) begin
          hs_cnt++;
          if (smp_burst_end) be_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_sample", 64'({smp_data, smp_gap, smp_end, smp_burst_end}), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            chk("sample", 64'({smp_data, smp_gap, smp_end, smp_burst_end}), 64'(e));
          end
        end
        hold_v   = smp_valid && !smp_ready;
        hold_vec = {smp_valid, smp_data, smp_gap, smp_end, smp_burst_end};
      end
    end
  end

  // Random back-pressure, active only while rand_en is set.
  initial begin
    forever begin
      @(posedge axis_clk);
      #1;
      if (rand_en) smp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic align();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic do_reset();
    axis_rst_n = 1'b0;
    s_tvalid   = 1'b0;
    exp_q.delete();
    exp_err    = 1'b0;
    @(posedge axis_clk);
    @(negedge axis_clk);
    chk("reset_outputs", 64'({smp_valid, smp_data, smp_gap, smp_end, smp_burst_end, err_rc0}), 64'h0);
    chk("reset_tready", 64'(s_tready), 64'h0);
    align();
    axis_rst_n = 1'b1;
  endtask

  // Holds s_tvalid high (caller drops it) and reports how many cycles it waited.
  task automatic send_pkt(input logic [31:0] pkt, input logic last, output int waits);
    s_tdata  = pkt;
    s_tlast  = last;
    s_tvalid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge axis_clk);
      if (s_tready) break;
      waits++;
      if (waits > 2000) begin
        chk("accept_timeout", 64'(waits), 64'h0);
        break;
      end
    end
    @(posedge axis_clk);
    if (waits <= 2000) model_pkt(pkt, last);
    #1;
  endtask

  task automatic idle_in();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge axis_clk);
      if (exp_q.size() == 0 && !smp_valid) break;
      n++;
      if (n > budget) begin
        chk("drain_timeout", 64'(exp_q.size()), 64'h0);
        break;
      end
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int w;
    int hs0, be0;

    do_reset();

    // 1: three-sample run, tready low while the run is in progress
    send_pkt(32'h03_0000A5, 1'b0, w);
    idle_in();
    @(negedge axis_clk);
    chk("t1_c1", 64'({smp_valid, smp_data, smp_end, s_tready}), {38'h0, 1'b1, 24'h0000A5, 1'b0, 1'b0});
    @(negedge axis_clk);
    chk("t1_c2", 64'({smp_valid, smp_data, smp_end, s_tready}), {38'h0, 1'b1, 24'h0000A5, 1'b0, 1'b0});
    @(negedge axis_clk);
    chk("t1_c3", 64'({smp_valid, smp_data, smp_end, s_tready}), {38'h0, 1'b1, 24'h0000A5, 1'b1, 1'b1});
    @(negedge axis_clk);
    chk("t1_done", 64'(smp_valid), 64'h0);
    align();

    // 2: back-to-back packets with tvalid held, no bubble
    send_pkt(32'h01_000001, 1'b0, w);
    send_pkt(32'h02_000002, 1'b0, w);
    chk("t2_no_bubble_wait", 64'(w), 64'h0);
    idle_in();
    @(negedge axis_clk);
    chk("t2_s2", 64'({smp_valid, smp_data, smp_end}), 64'({1'b1, 24'h000002, 1'b0}));
    @(negedge axis_clk);
    chk("t2_s3", 64'({smp_valid, smp_data, smp_end}), 64'({1'b1, 24'h000002, 1'b1}));
    wait_drain(50);
    align();

    // 3: null packet between runs, the gap closes a burst
    send_pkt(32'h01_000007, 1'b0, w);
    send_pkt(32'h00_000000, 1'b1, w);
    idle_in();
    @(negedge axis_clk);
    chk("t3_gap", 64'({smp_valid, smp_gap, smp_data, smp_end, smp_burst_end}),
        64'({1'b1, 1'b1, 24'h0, 1'b1, 1'b1}));
    align();
    send_pkt(32'h01_000008, 1'b0, w);
    idle_in();
    wait_drain(50);
    align();

    // 4: rc==0 with nonzero data is dropped and flagged until cleared
    send_pkt(32'h00_000010, 1'b0, w);
    idle_in();
    @(negedge axis_clk);
    chk("t4_err_set", 64'({smp_valid, err_rc0}), 64'h1);
    align();
    repeat (2) align();
    err_clr = 1'b1;
    @(posedge axis_clk);
    exp_err = 1'b0;
    #1;
    err_clr = 1'b0;
    @(negedge axis_clk);
    chk("t4_err_clr", 64'(err_rc0), 64'h0);
    align();
    send_pkt(32'h02_0000AB, 1'b0, w);
    idle_in();
    @(negedge axis_clk);
    chk("t4_recover", 64'({smp_valid, smp_data}), 64'({1'b1, 24'h0000AB}));
    wait_drain(50);
    align();

    // 5: maximal run under random back-pressure, ending a burst
    hs0 = hs_cnt;
    be0 = be_cnt;
    rand_en = 1'b1;
    send_pkt(32'hFF_123456, 1'b1, w);
    idle_in();
    wait_drain(3000);
    rand_en = 1'b0;
    align();
    smp_ready = 1'b1;
    chk("t5_count", 64'(hs_cnt - hs0), 64'd255);
    chk("t5_burst_end", 64'(be_cnt - be0), 64'd1);

    // 6: reset in the middle of a run, then a fresh packet
    send_pkt(32'hFF_00ABCD, 1'b0, w);
    idle_in();
    repeat (155) @(posedge axis_clk);
    #1;
    chk("t6_before_reset", 64'(exp_q.size()), 64'd100);
    do_reset();
    @(negedge axis_clk);
    chk("t6_after_reset", 64'(smp_valid), 64'h0);
    align();
    send_pkt(32'h02_000055, 1'b0, w);
    idle_in();
    @(negedge axis_clk);
    chk("t6_fresh", 64'({smp_valid, smp_data, smp_end}), 64'({1'b1, 24'h000055, 1'b0}));
    wait_drain(50);
    chk("final_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
